// File: rtl/force_ctrl_pkg.sv
// Shared types for the force/release responder: command opcodes and FSM states.
package force_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_FORCE     = 2'd0,
    OP_RELEASE   = 2'd1,
    OP_READ      = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

endpackage

// File: rtl/force_slot.sv
// One forceable signal: force-enable/value registers, masked update and effective value.
module force_slot #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             do_force,
  input  logic             do_release,
  input  logic             clear,
  input  logic [WIDTH-1:0] mask,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] sig_in,
  output logic [WIDTH-1:0] en_nxt,
  output logic [WIDTH-1:0] eff_nxt,
  output logic [WIDTH-1:0] sig_out
);

  logic [WIDTH-1:0] en_q, en_d;
  logic [WIDTH-1:0] val_q, val_d;

  always_comb begin
    en_d  = en_q;
    val_d = val_q;
    if (clear) begin
      en_d = '0;
    end else if (do_force) begin
      en_d  = en_q | mask;
      val_d = (val_q & ~mask) | (data & mask);
    end else if (do_release) begin
      en_d = en_q & ~mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      val_q <= '0;
    end else begin
      en_q  <= en_d;
      val_q <= val_d;
    end
  end

  // Post-update view lets the controller capture the response at the accept edge.
  assign en_nxt  = en_d;
  assign eff_nxt = (en_d & val_d) | (~en_d & sig_in);
  assign sig_out = (en_q & val_q) | (~en_q & sig_in);

endmodule

// File: rtl/force_ctrl.sv
// Force/release command responder: valid/ready command channel, one response per command.
module force_ctrl
  import force_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SIG = 4,
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned IDX_W   = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [IDX_W-1:0]         cmd_idx,
  input  logic [WIDTH-1:0]         cmd_mask,
  input  logic [WIDTH-1:0]         cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [WIDTH-1:0]         rsp_forced,
  output logic                     rsp_err,
  input  logic [NUM_SIG*WIDTH-1:0] sig_in,
  output logic [NUM_SIG*WIDTH-1:0] sig_out
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] forced;
    logic             err;
  } rsp_t;

  state_e state_q, state_d;
  rsp_t   rsp_q, rsp_d;

  op_e              op;
  logic             accept;
  logic             idx_err;
  logic             clear_all;
  logic [NUM_SIG-1:0] slot_force, slot_release;
  logic [WIDTH-1:0] en_nxt  [NUM_SIG];
  logic [WIDTH-1:0] eff_nxt [NUM_SIG];
  logic [WIDTH-1:0] sel_en, sel_eff;

  assign op        = op_e'(cmd_op);
  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign idx_err   = 32'(cmd_idx) >= NUM_SIG;
  assign clear_all = accept && (op == OP_CLEAR_ALL);

  for (genvar k = 0; k < NUM_SIG; k++) begin : g_slot
    assign slot_force[k]   = accept && (op == OP_FORCE) && !idx_err && (32'(cmd_idx) == k);
    assign slot_release[k] = accept && (op == OP_RELEASE) && !idx_err && (32'(cmd_idx) == k);

    force_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .do_force   (slot_force[k]),
      .do_release (slot_release[k]),
      .clear      (clear_all),
      .mask       (cmd_mask),
      .data       (cmd_data),
      .sig_in     (sig_in[k*WIDTH +: WIDTH]),
      .en_nxt     (en_nxt[k]),
      .eff_nxt    (eff_nxt[k]),
      .sig_out    (sig_out[k*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    sel_en  = '0;
    sel_eff = '0;
    for (int unsigned k = 0; k < NUM_SIG; k++) begin
      if (32'(cmd_idx) == k) begin
        sel_en  = en_nxt[k];
        sel_eff = eff_nxt[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_RESP;
          if (op == OP_CLEAR_ALL) begin
            rsp_d = '0;
          end else if (idx_err) begin
            rsp_d = '{data: '0, forced: '0, err: 1'b1};
          end else begin
            rsp_d = '{data: sel_eff, forced: sel_en, err: 1'b0};
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_q.data;
  assign rsp_forced = rsp_q.forced;
  assign rsp_err    = rsp_q.err;

endmodule

// File: tb/tb_force_ctrl.sv
// Scoreboard bench for force_ctrl with three slots so that index 3 is out of range.
module tb_force_ctrl;

  localparam int unsigned NS = 3;
  localparam int unsigned W  = 64;
  localparam int unsigned IW = 2;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] A5   = 64'hAAAAAAAA_AAAAAAAA;
  localparam logic [W-1:0] P5   = 64'h55555555_55555555;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [IW-1:0]   cmd_idx;
  logic [W-1:0]    cmd_mask;
  logic [W-1:0]    cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [W-1:0]    rsp_forced;
  logic            rsp_err;
  logic [NS*W-1:0] sig_in;
  logic [NS*W-1:0] sig_out;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] f;
    logic         e;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  force_ctrl #(
    .NUM_SIG(NS),
    .WIDTH  (W),
    .IDX_W  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_idx    (cmd_idx),
    .cmd_mask   (cmd_mask),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_forced (rsp_forced),
    .rsp_err    (rsp_err),
    .sig_in     (sig_in),
    .sig_out    (sig_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] out_of(input int k);
    return sig_out[k*W +: W];
  endfunction

  function automatic logic [W-1:0] in_of(input int k);
    return sig_in[k*W +: W];
  endfunction

  task automatic set_sig(input int k, input logic [W-1:0] v);
    sig_in[k*W +: W] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response side of the scoreboard: handshake completes at the following posedge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("rsp_data", rsp_data, e.d);
        check_eq("rsp_forced", rsp_forced, e.f);
        check_eq("rsp_err", {63'd0, rsp_err}, {63'd0, e.e});
      end
    end
  end

  // Called just after a posedge; returns just after the accept edge.
  task automatic send(input logic [1:0] op, input logic [IW-1:0] idx, input logic [W-1:0] mask,
                      input logic [W-1:0] data, input logic [W-1:0] ed, input logic [W-1:0] ef,
                      input logic ee, input bit push);
    int n = 0;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_mask  = mask;
    cmd_data  = data;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) check_eq("cmd_ready_timeout", 64'd0, 64'd1);
    if (push) sb.push_back('{d: ed, f: ef, e: ee});
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (!cmd_ready) check_eq("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_idx   = '0;
    cmd_mask  = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    sig_in    = '0;
    set_sig(0, 64'h11111111_11111111);
    set_sig(1, A5);
    set_sig(2, 64'h22222222_22222222);
    step();
    step();
    rst = 1'b0;
    step();

    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_rsp_data", rsp_data, 64'd0);
    check_eq("rst_rsp_forced", rsp_forced, 64'd0);
    check_eq("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
    for (int k = 0; k < NS; k++) check_eq("rst_passthru", out_of(k), in_of(k));

    // Full force of slot 1
    send(2'd0, 2'd1, ONES, P5, P5, ONES, 1'b0, 1'b1);
    check_eq("t1_forced_out", out_of(1), P5);
    set_sig(1, ~A5);
    #1;
    check_eq("t1_toggle_held", out_of(1), P5);
    check_eq("t1_slot0_follow", out_of(0), 64'h11111111_11111111);
    set_sig(0, 64'h0F0F0F0F_0F0F0F0F);
    #1;
    check_eq("t1_slot0_live", out_of(0), 64'h0F0F0F0F_0F0F0F0F);
    wait_idle();

    // Partial force of slot 2, then a second mask over different bits
    set_sig(2, A5);
    send(2'd0, 2'd2, 64'h00000000_FFFFFFFF, 64'h00000000_55555555,
         64'hAAAAAAAA_55555555, 64'h00000000_FFFFFFFF, 1'b0, 1'b1);
    check_eq("t2_partial_out", out_of(2), 64'hAAAAAAAA_55555555);
    wait_idle();
    send(2'd0, 2'd2, 64'hFF000000_00000000, 64'd0,
         64'h00AAAAAA_55555555, 64'hFF000000_FFFFFFFF, 1'b0, 1'b1);
    check_eq("t2_second_out", out_of(2), 64'h00AAAAAA_55555555);
    wait_idle();

    // Full release, read-back, then live tracking
    send(2'd1, 2'd2, ONES, 64'd0, A5, 64'd0, 1'b0, 1'b1);
    check_eq("t3_released_out", out_of(2), A5);
    wait_idle();
    send(2'd2, 2'd2, 64'd0, 64'd0, A5, 64'd0, 1'b0, 1'b1);
    wait_idle();
    set_sig(2, 64'h12345678_9ABCDEF0);
    #1;
    check_eq("t3_track", out_of(2), 64'h12345678_9ABCDEF0);

    // mask=0 force is a no-op reporting current state
    send(2'd0, 2'd1, 64'd0, 64'd0, P5, ONES, 1'b0, 1'b1);
    check_eq("t3_mask0_out", out_of(1), P5);
    wait_idle();

    // Backpressure on a pending response with a queued READ
    rsp_ready = 1'b0;
    send(2'd0, 2'd0, 64'h00000000_0000FFFF, 64'h00000000_0000BEEF,
         64'h0F0F0F0F_0F0FBEEF, 64'h00000000_0000FFFF, 1'b0, 1'b1);
    cmd_op    = 2'd2;
    cmd_idx   = 2'd0;
    cmd_mask  = '0;
    cmd_data  = '0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_sig(0, 64'hC0DE0000_00000000 + 64'(i));
      step();
      check_eq("t4_valid_held", {63'd0, rsp_valid}, 64'd1);
      check_eq("t4_data_stable", rsp_data, 64'h0F0F0F0F_0F0FBEEF);
      check_eq("t4_cmd_blocked", {63'd0, cmd_ready}, 64'd0);
    end
    v = 64'hC0DE0000_00000002;
    check_eq("t4_out_partial", out_of(0), {v[63:16], 16'hBEEF});
    rsp_ready = 1'b1;
    sb.push_back('{d: {v[63:16], 16'hBEEF}, f: 64'h00000000_0000FFFF, e: 1'b0});
    step();
    check_eq("t4_ready_after", {63'd0, cmd_ready}, 64'd1);
    check_eq("t4_valid_drop", {63'd0, rsp_valid}, 64'd0);
    step();
    cmd_valid = 1'b0;
    check_eq("t4_read_accepted", {63'd0, rsp_valid}, 64'd1);
    wait_idle();

    // Out-of-range index and CLEAR_ALL ignoring the index
    send(2'd0, 2'd3, ONES, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1);
    check_eq("t5_err_slot0", out_of(0), {v[63:16], 16'hBEEF});
    check_eq("t5_err_slot1", out_of(1), P5);
    check_eq("t5_err_slot2", out_of(2), in_of(2));
    wait_idle();
    send(2'd3, 2'd3, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    for (int k = 0; k < NS; k++) check_eq("t5_cleared", out_of(k), in_of(k));
    wait_idle();

    // Reset while a response is pending drops it and releases everything
    send(2'd0, 2'd0, ONES, 64'hDEADBEEF_DEADBEEF, 64'hDEADBEEF_DEADBEEF, ONES, 1'b0, 1'b1);
    wait_idle();
    rsp_ready = 1'b0;
    send(2'd0, 2'd1, ONES, 64'h0, 64'h0, ONES, 1'b0, 1'b0);
    check_eq("t6_slot0_forced", out_of(0), 64'hDEADBEEF_DEADBEEF);
    check_eq("t6_slot1_forced", out_of(1), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("t6_rsp_dropped", {63'd0, rsp_valid}, 64'd0);
    check_eq("t6_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    for (int k = 0; k < NS; k++) check_eq("t6_released", out_of(k), in_of(k));
    rsp_ready = 1'b1;
    step();

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
